// File: rtl/matrix_det_rr_scheduler.sv
// Round-robin front end sharing one 2x2 matrix-product determinant core among
// NUM_REQ requesters: grant, hold operands while the core settles, return the result.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | arbitrate; handshake with winner latches its operands
//   S_SETTLE  | core_enable high, operands stable, counting down to capture
//   S_RESPOND | rsp_valid to granted requester until it accepts
module matrix_det_rr_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*28-1:0]   req_matA,
    input  logic [NUM_REQ*28-1:0]   req_matB,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_det,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    core_enable,
    output logic [27:0]             core_matA,
    output logic [27:0]             core_matB,
    input  logic [27:0]             core_determinant
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_core_en;
    logic [27:0]         r_matA;
    logic [27:0]         r_matB;
    logic [31:0]         r_rsp_det;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic                w_handshake;
    logic                w_rsp_accept;
    logic                w_cnt_zero;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [NUM_REQ-1:0]  w_rsp_valid;

    // Search starts one past the last served requester and wraps.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_last_grant) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Gated by reset so no ready is shown for a handshake that cannot complete.
    assign w_handshake  = (r_state == S_IDLE) && w_found && !reset;
    assign w_rsp_accept = (r_state == S_RESPOND) && rsp_ready[r_grant_id];
    assign w_cnt_zero   = (r_cnt == '0);

    always_comb begin
        w_req_ready = '0;
        w_rsp_valid = '0;
        if (w_handshake) begin
            w_req_ready[w_winner] = 1'b1;
        end
        if (r_state == S_RESPOND) begin
            w_rsp_valid[r_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_handshake)  w_next = S_SETTLE;
            S_SETTLE:  if (w_cnt_zero)   w_next = S_RESPOND;
            S_RESPOND: if (w_rsp_accept) w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_cnt        <= '0;
            r_core_en    <= 1'b0;
            r_matA       <= '0;
            r_matB       <= '0;
            r_rsp_det    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_matA     <= req_matA[int'(w_winner)*28 +: 28];
                        r_matB     <= req_matB[int'(w_winner)*28 +: 28];
                        r_grant_id <= w_winner;
                        r_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        r_core_en  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_rsp_det <= {{4{core_determinant[27]}}, core_determinant};
                        r_core_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (w_rsp_accept) begin
                        r_last_grant <= r_grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_det     = r_rsp_det;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != S_IDLE);
    assign core_enable = r_core_en;
    assign core_matA   = r_matA;
    assign core_matB   = r_matB;

endmodule
